// File: rtl/matrix_frame_loader.sv
// Packs a serial element stream into a row-major 3x3 operand pair (A then B) for the multiplier.
// Latency: out_valid rises the cycle after the final B element is accepted.
// Backpressure: in_ready drops while a packed frame is held; the frame is released by out_ready.
module matrix_frame_loader #(
    parameter int ELEM_W = 16,
    parameter int N      = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ELEM_W-1:0]         in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N*N*ELEM_W-1:0]     out_a,
    output logic [N*N*ELEM_W-1:0]     out_b,
    output logic [4:0]                elem_idx,
    output logic                      frame_err
);

    localparam int NE = N * N;
    localparam int W  = NE * ELEM_W;

    localparam logic [1:0] S_LOAD_A = 2'd0;
    localparam logic [1:0] S_LOAD_B = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    localparam logic [4:0] LAST_IDX = 5'(NE - 1);

    logic [1:0]   state_q, state_d;
    logic [4:0]   idx_q,   idx_d;
    logic [W-1:0] a_q,     a_d;
    logic [W-1:0] b_q,     b_d;
    logic         err_q,   err_d;

    logic accept;
    logic last_slot;

    assign accept    = in_valid && (state_q != S_HOLD);
    assign last_slot = (idx_q == LAST_IDX);

    // Next-state: clear wins over everything, then per-state accept / handshake handling.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = 1'b0;

        if (in_clear) begin
            state_d = S_LOAD_A;
            idx_d   = 5'd0;
        end else begin
            case (state_q)
                S_LOAD_A: begin
                    if (accept) begin
                        // Element 0 lands in the MSBs; constant-select decode keeps slicing static.
                        for (int e = 0; e < NE; e++) begin
                            if (idx_q == 5'(e)) begin
                                a_d[(NE-1-e)*ELEM_W +: ELEM_W] = in_data;
                            end
                        end
                        if (in_last) begin
                            // in_last can never be legal inside matrix A.
                            err_d   = 1'b1;
                            state_d = S_LOAD_A;
                            idx_d   = 5'd0;
                        end else if (last_slot) begin
                            state_d = S_LOAD_B;
                            idx_d   = 5'd0;
                        end else begin
                            idx_d = idx_q + 5'd1;
                        end
                    end
                end
                S_LOAD_B: begin
                    if (accept) begin
                        for (int e = 0; e < NE; e++) begin
                            if (idx_q == 5'(e)) begin
                                b_d[(NE-1-e)*ELEM_W +: ELEM_W] = in_data;
                            end
                        end
                        if (in_last != last_slot) begin
                            // in_last must coincide exactly with the final B element.
                            err_d   = 1'b1;
                            state_d = S_LOAD_A;
                            idx_d   = 5'd0;
                        end else if (last_slot) begin
                            state_d = S_HOLD;
                            idx_d   = 5'd0;
                        end else begin
                            idx_d = idx_q + 5'd1;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state_d = S_LOAD_A;
                        idx_d   = 5'd0;
                    end
                end
                default: begin
                    state_d = S_LOAD_A;
                    idx_d   = 5'd0;
                end
            endcase
        end
    end

    // State and data registers; reset zeros the operand words as well.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LOAD_A;
            idx_q   <= 5'd0;
            a_q     <= '0;
            b_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q != S_HOLD);
    assign out_valid = (state_q == S_HOLD);
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign elem_idx  = idx_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_matrix_frame_loader.sv
// Directed bench for matrix_frame_loader with a frame scoreboard.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Packed frames are predicted when driven and compared at the output handshake.
module tb_matrix_frame_loader;

    typedef struct packed {
        logic [143:0] a;
        logic [143:0] b;
    } frame_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_clear;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [143:0] out_a;
    logic [143:0] out_b;
    logic [4:0]   elem_idx;
    logic         frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    int first_acc_cyc = 0;
    int hs_cyc = 0;
    int vld_cnt = 0;

    logic [15:0]  cur [18];
    frame_t       sb [$];
    logic [143:0] snap_a, snap_b;

    matrix_frame_loader #(.ELEM_W(16), .N(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_clear  (in_clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .elem_idx  (elem_idx),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [143:0] pack9(input int base);
        logic [143:0] r;
        r = '0;
        for (int e = 0; e < 9; e++) r[(8-e)*16 +: 16] = cur[base+e];
        return r;
    endfunction

    // mode 0: A = 1..9, B = 9..1; otherwise random contents.
    task automatic set_cur(input int mode);
        for (int e = 0; e < 9; e++) begin
            cur[e]   = (mode == 0) ? 16'(e + 1) : 16'($urandom);
            cur[9+e] = (mode == 0) ? 16'(9 - e) : 16'($urandom);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic last, input int gap);
        logic acc;
        logic ok;
        in_valid = 1'b0;
        repeat (gap) step();
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            acc = in_ready;
            if (acc) last_acc_cyc = cyc;
            step();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout: observed no accept expected accept within 100 cycles");
        end
    endtask

    // Sends n elements of cur; bad_at >= 0 places in_last on that element instead of element 17.
    task automatic send_frame(input int maxgap, input int n, input int bad_at);
        frame_t f;
        logic   last;
        if (n == 18 && bad_at < 0) begin
            f.a = pack9(0);
            f.b = pack9(9);
            sb.push_back(f);
        end
        for (int e = 0; e < n; e++) begin
            last = (bad_at >= 0) ? (e == bad_at) : (e == 17);
            send(cur[e], last, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
            if (e == 0) first_acc_cyc = last_acc_cyc;
            if (bad_at < 0 || e < bad_at) chk("elem_idx_adv", elem_idx, 5'((e + 1) % 9));
        end
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 60; t++) begin
            if (sb.size() == 0 && !out_valid) break;
            step();
        end
        chk("drain", sb.size(), 0);
    endtask

    // Output monitor: a handshake happens on the next rising edge when these hold now.
    always @(negedge clk) begin
        frame_t f;
        if (!rst) begin
            if (out_valid) vld_cnt++;
            if (out_valid && out_ready && !in_clear) begin
                hs_cyc = cyc;
                chk("hold_in_ready", in_ready, 1'b0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_frame: observed out_a %0h expected no frame", out_a);
                end else begin
                    f = sb.pop_front();
                    chk("out_a", out_a, f.a);
                    chk("out_b", out_b, f.b);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_clear  = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #2;
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_a",     out_a,     144'd0);
        chk("rst_out_b",     out_b,     144'd0);
        chk("rst_elem_idx",  elem_idx,  5'd0);
        chk("rst_frame_err", frame_err, 1'b0);
        #10;
        rst = 1'b0;
        step();

        // Basic frame with continuous input and a ready consumer.
        set_cur(0);
        vld_cnt = 0;
        send_frame(0, 18, -1);
        chk("basic_vld_after_last", out_valid, 1'b1);
        chk("basic_a_msb", out_a[143:128], 16'd1);
        chk("basic_a_lsb", out_a[15:0],    16'd9);
        chk("basic_b_msb", out_b[143:128], 16'd9);
        wait_drain();
        chk("basic_vld_cycles", vld_cnt, 1);
        chk("basic_latency", hs_cyc - first_acc_cyc + 1, 19);

        // Backpressure: frame held while the input keeps toggling.
        set_cur(1);
        out_ready = 1'b0;
        send_frame(0, 18, -1);
        chk("bp_vld", out_valid, 1'b1);
        snap_a = out_a;
        snap_b = out_b;
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            in_data  = 16'($urandom);
            in_last  = 1'($urandom);
            step();
            chk("bp_hold_vld",   out_valid, 1'b1);
            chk("bp_hold_ready", in_ready,  1'b0);
            chk("bp_hold_a",     out_a,     snap_a);
            chk("bp_hold_b",     out_b,     snap_b);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release_ready", in_ready,  1'b1);
        chk("bp_release_vld",   out_valid, 1'b0);
        wait_drain();

        // Input gaps: same data as the basic frame.
        set_cur(0);
        send_frame(3, 18, -1);
        wait_drain();

        // Bad in_last on element 12 (B slot 2).
        set_cur(1);
        send_frame(0, 12, 11);
        chk("bad_err_pulse", frame_err, 1'b1);
        chk("bad_elem_idx",  elem_idx,  5'd0);
        chk("bad_out_valid", out_valid, 1'b0);
        chk("bad_in_ready",  in_ready,  1'b1);
        step();
        chk("bad_err_one_cycle", frame_err, 1'b0);
        set_cur(1);
        send_frame(1, 18, -1);
        wait_drain();

        // Clear at elem_idx 4 in LOAD_B with an element offered.
        set_cur(1);
        send_frame(0, 13, -1);
        in_clear = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hdead;
        step();
        in_clear = 1'b0;
        in_valid = 1'b0;
        chk("clr_elem_idx",  elem_idx,  5'd0);
        chk("clr_frame_err", frame_err, 1'b0);
        chk("clr_out_valid", out_valid, 1'b0);
        set_cur(1);
        send_frame(0, 18, -1);
        wait_drain();

        // Asynchronous reset mid-LOAD_A, away from any clock edge.
        set_cur(1);
        send_frame(0, 5, -1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_out_a",     out_a,     144'd0);
        chk("arst_out_b",     out_b,     144'd0);
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_elem_idx",  elem_idx,  5'd0);
        chk("arst_in_ready",  in_ready,  1'b1);
        #2;
        rst = 1'b0;
        step();
        set_cur(1);
        send_frame(2, 18, -1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
